// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: divider FSM states, iteration count and DIV/DIVU decode constants.
package mips_defs_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = DIV_WIDTH;

    // R-type encodings that maindec turns into startE/signedE
    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/div_core.sv
// Restoring divider datapath: remainder/quotient shift registers and one subtract step per strobe.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] loadRem,
    input  logic [WIDTH-1:0] loadQuot,
    input  logic [WIDTH-1:0] loadDvsr,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] quot
);

    logic [WIDTH-1:0] dvsr;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   remDiff;
    logic             geq;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuot;

    // Quotient register initially holds the dividend; its MSB feeds the remainder each step.
    always_comb begin
        remShift = {rem, quot[WIDTH-1]};
        remDiff  = remShift - {1'b0, dvsr};
        geq      = (remShift >= {1'b0, dvsr});
        nextRem  = geq ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
        nextQuot = {quot[WIDTH-2:0], geq};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem  <= '0;
            quot <= '0;
            dvsr <= '0;
        end else if (load) begin
            rem  <= loadRem;
            quot <= loadQuot;
            dvsr <= loadDvsr;
        end else if (step) begin
            rem  <= nextRem;
            quot <= nextQuot;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU sequencer: FSM, iteration counter, sign handling, stall and ready generation.
// Optional DIV_ZERO_FAST_EN: a zero divisor skips the iterations and goes straight to DONE.
module div_sequencer
    import mips_defs_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] aE,
    input  logic [WIDTH-1:0] bE,
    input  logic             cancelE,
    output logic             stall_divE,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    function automatic logic [WIDTH-1:0] negIf(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + WIDTH'(1)) : x;
    endfunction

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             signQ;
    logic             signR;
    logic [WIDTH-1:0] loHold;
    logic [WIDTH-1:0] hiHold;

    logic             accept;
    logic             step;
    logic             zeroFast;
    logic [WIDTH-1:0] aMag;
    logic [WIDTH-1:0] bMag;
    logic [WIDTH-1:0] loadRem;
    logic [WIDTH-1:0] loadQuot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] loFixed;
    logic [WIDTH-1:0] hiFixed;

    always_comb begin
        accept = (state == DIV_IDLE) && startE && !cancelE;
        step   = (state == DIV_RUN) && startE && !cancelE;
        aMag   = negIf(aE, signedE && aE[WIDTH-1]);
        bMag   = negIf(bE, signedE && bE[WIDTH-1]);
`ifdef DIV_ZERO_FAST_EN
        zeroFast = (bE == '0);
`else
        zeroFast = 1'b0;
`endif
        // Fast path preloads what the full iteration would produce: q all ones, r = |a|
        loadRem  = zeroFast ? aMag : '0;
        loadQuot = zeroFast ? '1 : aMag;
        loFixed  = negIf(quot, signQ);
        hiFixed  = negIf(rem, signR);
    end

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (step),
        .loadRem  (loadRem),
        .loadQuot (loadQuot),
        .loadDvsr (bMag),
        .rem      (rem),
        .quot     (quot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DIV_IDLE;
            cnt    <= '0;
            signQ  <= 1'b0;
            signR  <= 1'b0;
            loHold <= '0;
            hiHold <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        signQ <= signedE && (aE[WIDTH-1] ^ bE[WIDTH-1]);
                        signR <= signedE && aE[WIDTH-1];
                        cnt   <= '0;
                        state <= zeroFast ? DIV_DONE : DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    // A dropped startE without a flush still means the instruction left execute
                    if (!step) begin
                        state <= DIV_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    state <= DIV_IDLE;
                    if (!cancelE) begin
                        loHold <= loFixed;
                        hiHold <= hiFixed;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    // Results are presented combinationally during ready, then held for later reads
    assign ready      = (state == DIV_DONE) && !cancelE && !rst;
    assign busy       = (state != DIV_IDLE);
    assign stall_divE = startE && !ready && !cancelE && !rst;
    assign lo_out     = ready ? loFixed : loHold;
    assign hi_out     = ready ? hiFixed : hiHold;

endmodule
